// File: rtl/cipher_pkg.sv
// Shared mode encodings and word transforms for the stream cipher pipeline.
// Transforms take a run-time width so one package serves every WIDTH instance.
package cipher_pkg;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_ENC = 1'b1;

    localparam int unsigned MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    // Odd slot k takes slot (k-1 mod n); even bits pass through untouched.
    function automatic word_t odd_rot_dec(word_t w, int unsigned width);
        word_t       r;
        int unsigned n;
        logic [5:0]  dst;
        logic [5:0]  src;
        r = w;
        n = width / 2;
        for (int unsigned k = 0; k < MAX_W / 2; k++) begin
            if (k < n) begin
                dst    = 6'(2 * k + 1);
                src    = 6'(2 * ((k + n - 1) % n) + 1);
                r[dst] = w[src];
            end
        end
        return r;
    endfunction

    // Inverse of odd_rot_dec: odd slot k takes slot (k+1 mod n).
    function automatic word_t odd_rot_enc(word_t w, int unsigned width);
        word_t       r;
        int unsigned n;
        logic [5:0]  dst;
        logic [5:0]  src;
        r = w;
        n = width / 2;
        for (int unsigned k = 0; k < MAX_W / 2; k++) begin
            if (k < n) begin
                dst    = 6'(2 * k + 1);
                src    = 6'(2 * ((k + 1) % n) + 1);
                r[dst] = w[src];
            end
        end
        return r;
    endfunction

    function automatic word_t even_invert(word_t w, int unsigned width);
        word_t      r;
        logic [5:0] idx;
        r = w;
        for (int unsigned i = 0; i < MAX_W; i += 2) begin
            if (i < width) begin
                idx    = 6'(i);
                r[idx] = ~w[idx];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/odd_slot_rotate.sv
// Combinational rotation of the odd-bit slots of a word; DIR picks the direction.
module odd_slot_rotate
    import cipher_pkg::*;
#(
    parameter int unsigned WIDTH = 7,
    parameter logic        DIR   = MODE_DEC
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] rotated
);

    word_t padded;
    assign padded = word_t'(word);

    if (DIR == MODE_DEC) begin : g_dec
        assign rotated = WIDTH'(odd_rot_dec(padded, WIDTH));
    end else begin : g_enc
        assign rotated = WIDTH'(odd_rot_enc(padded, WIDTH));
    end

endmodule

// File: rtl/stream_cipher_pipe.sv
// Two-stage valid/ready cipher pipeline: per-word encrypt/decrypt with a loadable,
// optionally rolling key and a completed-word counter.
module stream_cipher_pipe
    import cipher_pkg::*;
#(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned ROLL_EN = 0,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  logic [WIDTH-1:0]   key_in,
    output logic               key_valid,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_mode,
    output logic [COUNT_W-1:0] word_count
);

    logic [WIDTH-1:0]   key_q;
    logic               key_valid_q;
    logic               s1_valid_q;
    logic               s1_mode_q;
    logic [WIDTH-1:0]   s1_data_q;
    logic [WIDTH-1:0]   s1_key_q;
    logic               out_valid_q;
    logic               out_mode_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [COUNT_W-1:0] count_q;

    logic             out_adv;
    logic             s1_adv;
    logic             ready;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] enc_perm;
    logic [WIDTH-1:0] dec_perm;
    logic [WIDTH-1:0] s1_next;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] key_rolled;

    odd_slot_rotate #(
        .WIDTH (WIDTH),
        .DIR   (MODE_ENC)
    ) u_rot_enc (
        .word    (in_data),
        .rotated (enc_perm)
    );

    odd_slot_rotate #(
        .WIDTH (WIDTH),
        .DIR   (MODE_DEC)
    ) u_rot_dec (
        .word    (s1_data_q),
        .rotated (dec_perm)
    );

    always_comb begin
        out_adv    = !out_valid_q || out_ready;
        s1_adv     = !s1_valid_q || out_adv;
        ready      = key_valid_q && !key_load && s1_adv;
        accept     = in_valid && ready;
        xfer       = out_valid_q && out_ready;
        key_rolled = {key_q[WIDTH-2:0], key_q[WIDTH-1]};
        // Encrypt does its keyless half first so the key XOR can land in stage 2.
        if (in_mode == MODE_ENC) begin
            s1_next = WIDTH'(even_invert(word_t'(enc_perm), WIDTH));
        end else begin
            s1_next = in_data ^ key_q;
        end
        if (s1_mode_q == MODE_ENC) begin
            out_next = s1_data_q ^ s1_key_q;
        end else begin
            out_next = WIDTH'(even_invert(word_t'(dec_perm), WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else if (key_load) begin
            key_q       <= key_in;
            key_valid_q <= 1'b1;
        end else if (ROLL_EN != 0 && accept) begin
            key_q <= key_rolled;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_DEC;
            s1_data_q  <= '0;
            s1_key_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_mode_q <= in_mode;
                s1_data_q <= s1_next;
                s1_key_q  <= key_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= MODE_DEC;
            out_data_q  <= '0;
        end else if (out_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_mode_q <= s1_mode_q;
                out_data_q <= out_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign key_valid  = key_valid_q;
    assign in_ready   = ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_mode   = out_mode_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_stream_cipher_pipe.sv
// Randomised bench for stream_cipher_pipe: four instances (static, rolling/3-bit count,
// 3-bit and 15-bit words) share stimulus and are scored against a slot-level model.
module tb_stream_cipher_pipe;
    import cipher_pkg::*;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, key_load, in_valid, in_mode, out_ready;
    logic [14:0] key_in, in_data;
    logic        rdy [NI];
    logic        kv  [NI];
    logic        ov  [NI];
    logic        om  [NI];
    logic [6:0]  od_a, od_b;
    logic [2:0]  od_c;
    logic [14:0] od_d;
    logic [15:0] wc_a, wc_c, wc_d;
    logic [2:0]  wc_b;
    logic [14:0] od [NI];
    logic [15:0] wc [NI];

    always_comb begin
        od[0] = 15'(od_a);
        od[1] = 15'(od_b);
        od[2] = 15'(od_c);
        od[3] = od_d;
        wc[0] = wc_a;
        wc[1] = 16'(wc_b);
        wc[2] = wc_c;
        wc[3] = wc_d;
    end

    stream_cipher_pipe #(.WIDTH(7), .ROLL_EN(0), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in[6:0]),
        .key_valid(kv[0]), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data[6:0]),
        .in_mode(in_mode), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od_a),
        .out_mode(om[0]), .word_count(wc_a));

    stream_cipher_pipe #(.WIDTH(7), .ROLL_EN(1), .COUNT_W(3)) u_roll (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in[6:0]),
        .key_valid(kv[1]), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data[6:0]),
        .in_mode(in_mode), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_b),
        .out_mode(om[1]), .word_count(wc_b));

    stream_cipher_pipe #(.WIDTH(3), .ROLL_EN(0), .COUNT_W(16)) u_w3 (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in[2:0]),
        .key_valid(kv[2]), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data[2:0]),
        .in_mode(in_mode), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od_c),
        .out_mode(om[2]), .word_count(wc_c));

    stream_cipher_pipe #(.WIDTH(15), .ROLL_EN(0), .COUNT_W(16)) u_w15 (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .key_valid(kv[3]), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
        .in_mode(in_mode), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od_d),
        .out_mode(om[3]), .word_count(wc_d));

    int          iw   [NI] = '{7, 7, 3, 15};
    int          iroll[NI] = '{0, 1, 0, 0};
    int          icw  [NI] = '{16, 3, 16, 16};
    logic [15:0] mkey [NI];
    logic [15:0] exp_q[NI][$];
    int          cnt  [NI];
    logic        stalled[NI];
    logic [14:0] got7[$];
    logic [14:0] gotr[$];
    logic [14:0] encq[$];
    int          errors = 0;
    int          checks = 0;
    int          rdy_mode = 0;
    logic        acc, rdy0_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wmask(input int w);
        return 16'((32'd1 << w) - 1);
    endfunction

    // Reference: split into even bits and a list of odd slots, then apply the rules.
    function automatic logic [15:0] ref_cipher(input logic [15:0] msg, input logic [15:0] key,
                                               input logic mode, input int w);
        int          n = w / 2;
        bit          slot[8];
        logic [15:0] src, res;
        src = (mode == MODE_DEC) ? (msg ^ key) : msg;
        for (int k = 0; k < n; k++) slot[k] = src[2*k+1];
        res = '0;
        for (int b = 0; b < w; b += 2) res[b] = ~src[b];
        for (int k = 0; k < n; k++)
            res[2*k+1] = (mode == MODE_DEC) ? slot[(k+n-1)%n] : slot[(k+1)%n];
        if (mode == MODE_ENC) res = res ^ key;
        return res & wmask(w);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            mkey[i]    = '0;
            cnt[i]     = 0;
            stalled[i] = 1'b0;
        end
    endtask

    // One clock: set out_ready, sample just after, score, update model, end at negedge.
    task automatic cycle();
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        #1;
        acc       = in_valid && rdy[0];
        rdy0_seen = rdy[0];
        for (int i = 0; i < NI; i++) begin
            if (stalled[i]) check_eq($sformatf("hold%0d", i), 32'(ov[i]), 32'd1);
            if (ov[i]) begin
                if (exp_q[i].size() == 0) begin
                    check_eq($sformatf("spurious%0d", i), 32'(ov[i]), 32'd0);
                end else begin
                    check_eq($sformatf("out%0d", i), 32'({om[i], od[i]}), 32'(exp_q[i][0]));
                    if (out_ready) begin
                        void'(exp_q[i].pop_front());
                        cnt[i]++;
                        if (i == 0) got7.push_back(od[0]);
                        if (i == 1) gotr.push_back(od[1]);
                    end
                end
            end
            stalled[i] = ov[i] && !out_ready;
        end
        if (acc) begin
            for (int i = 0; i < NI; i++) begin
                exp_q[i].push_back({in_mode, 15'(ref_cipher(16'(in_data) & wmask(iw[i]),
                                                            mkey[i], in_mode, iw[i]))});
                if (iroll[i] != 0)
                    mkey[i] = ((mkey[i] << 1) | (mkey[i] >> (iw[i] - 1))) & wmask(iw[i]);
            end
        end
        if (key_load) begin
            for (int i = 0; i < NI; i++) mkey[i] = 16'(key_in) & wmask(iw[i]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [14:0] d, input logic m);
        logic done = 1'b0;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            cycle();
            done = acc;
        end
        check_eq("send_accept", 32'(done), 32'd1);
    endtask

    task automatic load_key(input logic [14:0] k, input logic with_valid);
        key_load = 1'b1;
        key_in   = k;
        in_valid = with_valid;
        in_data  = '0;
        in_mode  = MODE_DEC;
        cycle();
        if (with_valid) check_eq("keyload_blocks", 32'(rdy0_seen), 32'd0);
        key_load = 1'b0;
    endtask

    task automatic drain();
        int pending = 0;
        in_valid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            pending = 0;
            for (int i = 0; i < NI; i++) pending += exp_q[i].size();
            if (pending == 0) break;
            cycle();
        end
        check_eq("drain", 32'(pending), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; key_load = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        out_ready = 1'b1; key_in = '0; in_data = '0;
        clear_model();
        #3;
        check_eq("rst_out_valid", 32'(ov[0]), 32'd0);
        check_eq("rst_key_valid", 32'(kv[0]), 32'd0);
        check_eq("rst_in_ready", 32'(rdy[0]), 32'd0);
        check_eq("rst_out_data", 32'(od[0]), 32'd0);
        check_eq("rst_count", 32'(wc[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No key loaded yet: nothing may be accepted.
        in_valid = 1'b1;
        repeat (4) begin
            cycle();
            check_eq("nokey_ready", 32'(rdy0_seen), 32'd0);
            check_eq("nokey_out_valid", 32'(ov[0]), 32'd0);
        end

        got7.delete();
        load_key(15'h00, 1'b1);
        check_eq("key_valid_set", 32'(kv[0]), 32'd1);
        send(15'h00, MODE_DEC);
        in_valid = 1'b0;
        check_eq("lat_cycle1", 32'(ov[0]), 32'd0);
        cycle();
        check_eq("lat_cycle2", 32'(ov[0]), 32'd1);
        send(15'h02, MODE_DEC);
        send(15'h5D, MODE_ENC);
        drain();
        check_eq("dir_count", 32'(got7.size()), 32'd3);
        check_eq("dec_k00_m00", 32'(got7[0]), 32'h55);
        check_eq("dec_k00_m02", 32'(got7[1]), 32'h5D);
        check_eq("enc_k00_m5d", 32'(got7[2]), 32'h02);

        gotr.delete();
        got7.delete();
        load_key(15'h01, 1'b1);
        send(15'h00, MODE_DEC);
        send(15'h00, MODE_DEC);
        load_key(15'h7F, 1'b1);
        send(15'h00, MODE_DEC);
        drain();
        check_eq("roll_count", 32'(gotr.size()), 32'd3);
        check_eq("roll_first", 32'(gotr[0]), 32'h54);
        check_eq("roll_second", 32'(gotr[1]), 32'h5D);
        check_eq("roll_newkey", 32'(gotr[2]), 32'h2A);
        check_eq("static_k7f", 32'(got7[2]), 32'h2A);

        // Round trip over every 7-bit message with a random key and random backpressure.
        rdy_mode = 2;
        load_key(15'($urandom), 1'b0);
        got7.delete();
        for (int m = 0; m < 128; m++) send(15'(m), MODE_ENC);
        drain();
        encq = got7;
        got7.delete();
        for (int m = 0; m < encq.size(); m++) send(encq[m], MODE_DEC);
        drain();
        check_eq("rt_count", 32'(got7.size()), 32'd128);
        for (int m = 0; m < got7.size(); m++) check_eq("roundtrip", 32'(got7[m]), 32'(m));

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) load_key(15'($urandom), 1'($urandom_range(0, 1)));
            else send(15'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        for (int i = 0; i < NI; i++)
            check_eq($sformatf("count%0d", i), 32'(wc[i]), 32'(16'(cnt[i]) & wmask(icw[i])));

        // Alternating backpressure, then the ninth word wraps the 3-bit counter.
        do_reset();
        check_eq("bp_count0", 32'(wc[0]), 32'd0);
        load_key(15'($urandom), 1'b0);
        rdy_mode = 1;
        for (int n = 0; n < 8; n++) send(15'($urandom), 1'($urandom_range(0, 1)));
        drain();
        check_eq("bp_count8", 32'(wc[0]), 32'd8);
        send(15'($urandom), MODE_DEC);
        drain();
        check_eq("wrap_count", 32'(wc[1]), 32'd1);
        check_eq("count9", 32'(wc[0]), 32'd9);

        // Two words in flight, then reset in mid-cycle.
        rdy_mode = 3;
        send(15'h11, MODE_DEC);
        send(15'h22, MODE_ENC);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_out_valid", 32'(ov[0]), 32'd0);
        check_eq("async_key_valid", 32'(kv[0]), 32'd0);
        check_eq("async_count", 32'(wc[0]), 32'd0);
        clear_model();
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        in_valid = 1'b1;
        repeat (3) begin
            cycle();
            check_eq("post_rst_ready", 32'(rdy0_seen), 32'd0);
        end
        check_eq("post_rst_out_valid", 32'(ov[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_cipher_pipe.md
Name: stream_cipher_pipe

Overview:
- Parametrised, pipelined successor to the 7-bit combinational decrypter, sitting between the message source and the message sink.
- Handles WIDTH-bit words in either direction: encrypt or decrypt, selected per word.
- Holds a loadable key register, with optional per-word key rolling.
- Streams words through a 2-stage valid/ready pipeline and keeps a count of completed words.

Parameters:
- WIDTH, 7: word and key width. Must be odd and ≥3. N_ODD = WIDTH/2 (odd bit positions 1,3,..,WIDTH-2).
- ROLL_EN, 0: 1 = rotate the key left by 1 after each accepted word; 0 = key is static.
- COUNT_W, 16: width of the output word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_load  in  1  load key_in into the key register this cycle.
- key_in  in  WIDTH  new key value.
- key_valid  out  1  a key has been loaded since reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  WIDTH  message word.
- in_mode  in  1  0 = decrypt, 1 = encrypt; sampled with the word.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts the output word.
- out_data  out  WIDTH  result word.
- out_mode  out  1  mode the result was produced with.
- word_count  out  COUNT_W  number of output handshakes completed, modulo 2^COUNT_W.

Behaviour:
- Reset (async assert, sync-released use): key_reg = 0, key_valid = 0, both stage valids = 0, out_valid = 0, out_data = 0, out_mode = 0, word_count = 0, in_ready = 0.
- Odd-slot permutation: odd slot k ↔ bit 2k+1.
  - Decrypt: out slot k = intermediate slot (k-1 mod N_ODD).
  - Encrypt uses the inverse: slot k takes slot (k+1 mod N_ODD).
- Decrypt:
  - intermediate = in_data ^ key.
  - Even bits of the result = ~intermediate.
  - Odd bits = decrypt permutation of the intermediate.
- Encrypt (exact inverse of decrypt for the same key):
  - Even bits of t = ~in_data; odd bits of t = encrypt permutation.
  - Result = t ^ key.
- Stage 1, decrypt words: registers the XOR with the current key_reg.
- Stage 1, encrypt words: registers the inverted/permuted value and captures key_reg alongside it.
- Stage 2 (output register): completes the remaining operation (decrypt: invert/permute; encrypt: XOR with the captured key).
- Key binding: the key that applies to a word is the key_reg value on its accept cycle, regardless of later key loads.
- Latency: an accepted word appears on out_valid exactly 2 cycles later when out_ready has been held high. Throughput is 1 word/cycle.
- Handshake:
  - Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = key_valid & !key_load & (stage 1 can advance).
  - A stage advances when its successor is empty or is transferring in the same cycle.
  - out_data, out_mode and out_valid hold stable while out_valid & !out_ready.
  - No bubbles are inserted while the pipeline is full and out_ready is high.
- Key load:
  - key_load writes key_in into key_reg and sets key_valid.
  - It has priority over input accept: in_ready = 0 in that cycle.
  - Words already in flight complete with their bound key.
- Rolling (ROLL_EN = 1):
  - On each accept, key_reg is updated to {key_reg[WIDTH-2:0], key_reg[WIDTH-1]}.
  - If key_load coincides, key_load wins; no accept occurs in that cycle.
- word_count increments on each output transfer and wraps from 2^COUNT_W-1 to 0.
- Reset mid-stream: all in-flight words are discarded and the key is cleared. A new key_load is required before any accept.

Decomposition:
- Package cipher_pkg:
  - MODE_DEC = 1'b0 and MODE_ENC = 1'b1.
  - Functions odd_rot_dec(word) / odd_rot_enc(word), parametrised on WIDTH.
  - Function even_invert(word).
- Sub-module odd_slot_rotate (parameters WIDTH, DIR): purely combinational permutation of the odd slots, instantiated once for each direction.

Test Plan:
- Decrypt, WIDTH = 7, key 0x00, msg 0x00 → out 0x55. Key 0x7F, msg 0x00 → out 0x2A.
- Permutation direction: key 0x00, msg 0x02, decrypt → 0x5D. Then msg 0x5D, encrypt → 0x02. Randomised round-trip over all 128 msgs and random keys: encrypt then decrypt returns the original.
- Rolling, ROLL_EN = 1, key 0x01, two decrypts of 0x00 → 0x54 then 0x5D. Key_load in the same cycle as in_valid → in_ready = 0 and the new key is used by the next word.
- Backpressure: 8 back-to-back words with out_ready toggled 1/0 on alternate cycles → no loss or duplication, order preserved, outputs stable while stalled, word_count = 8.
- No key after reset: in_valid held high → in_ready = 0, out_valid = 0. Assert rst_n low with 2 words in flight → out_valid = 0, key_valid = 0, word_count = 0 immediately (asynchronously).
- Wrap: COUNT_W = 3, 9 transfers → word_count = 1. WIDTH = 3 and WIDTH = 15 variants pass the round-trip check.
